// File: rtl/hdl_test_pkg.sv
// hdl_test_pkg: default parameters and the event record shared by the time base and its FIFO.
package hdl_test_pkg;
   localparam int DEF_CNT_W  = 32;
   localparam int DEF_PER_W  = 16;
   localparam int DEF_PERIOD = 100;
   localparam int DEF_DEPTH  = 4;
   // Fields are sized for the widest supported build; narrower builds zero-extend.
   typedef struct packed {
      logic [DEF_CNT_W-1:0] ts;
      logic [DEF_PER_W-1:0] seq;
   } evt_t;
endpackage

// File: rtl/hdl_test_evt_fifo.sv
// hdl_test_evt_fifo: event queue; a push into a full queue only lands when a pop frees the slot.
module hdl_test_evt_fifo
   import hdl_test_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  evt_t                     din,
   output evt_t                     dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);
   evt_t mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic do_pop, do_push;
   always_comb begin
      valid   = count != '0;
      do_pop  = pop & valid;
      do_push = push & ((count != (AW+1)'(DEPTH)) | do_pop);
      drop    = push & ~do_push;
      dout    = valid ? mem[rd] : '0;
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/hdl_test.sv
// hdl_test: tick counter with a programmable-period event sequencer feeding a timestamped event FIFO.
module hdl_test
   import hdl_test_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int PER_W      = DEF_PER_W,
   parameter int DEF_PERIOD = hdl_test_pkg::DEF_PERIOD,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick_en,
   input  logic                   period_load,
   input  logic [PER_W-1:0]       period_in,
   input  logic                   evt_ready,
   output logic                   evt_valid,
   output logic [CNT_W-1:0]       evt_time,
   output logic [PER_W-1:0]       evt_seq,
   output logic [CNT_W-1:0]       tick_count,
   output logic [$clog2(DEPTH):0] pending,
   output logic                   overflow
);
   logic [PER_W-1:0] period, phase, seq, last;
   logic evt, drop;
   evt_t din, head;
   always_comb begin
      last     = period == '0 ? '0 : period - 1'b1;
      evt      = tick_en & ~period_load & (phase == last);
      din      = '{ts: DEF_CNT_W'(tick_count), seq: DEF_PER_W'(seq)};
      evt_time = CNT_W'(head.ts);
      evt_seq  = PER_W'(head.seq);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_count <= '0;
         phase      <= '0;
         seq        <= '0;
         period     <= PER_W'(DEF_PERIOD);
         overflow   <= 1'b0;
      end else begin
         if (tick_en) tick_count <= tick_count + 1'b1;
         if (period_load) begin
            period <= period_in;
            phase  <= '0;
         end else if (tick_en) phase <= evt ? '0 : phase + 1'b1;
         if (evt & ~drop) seq <= seq + 1'b1;
         if (drop) overflow <= 1'b1;
      end
   end
   hdl_test_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (evt),
      .pop   (evt_ready),
      .din   (din),
      .dout  (head),
      .valid (evt_valid),
      .count (pending),
      .drop  (drop)
   );
endmodule

// File: tb/tb_hdl_test.sv
// tb_hdl_test: directed stimulus with a queue scoreboard of expected events for hdl_test.
module tb_hdl_test;
   logic clk = 0, rst = 1, tick_en = 0, period_load = 0, evt_ready = 0;
   logic [15:0] period_in = 0;
   logic evt_valid, overflow;
   logic [31:0] evt_time, tick_count;
   logic [15:0] evt_seq;
   logic [2:0] pending;
   logic s_rst = 1, s_te = 0;
   logic s_valid, s_ovf;
   logic [3:0] s_time, s_tc;
   logic [15:0] s_seq;
   logic [2:0] s_pend;

   hdl_test dut (
      .clk(clk), .rst(rst), .tick_en(tick_en), .period_load(period_load),
      .period_in(period_in), .evt_ready(evt_ready), .evt_valid(evt_valid),
      .evt_time(evt_time), .evt_seq(evt_seq), .tick_count(tick_count),
      .pending(pending), .overflow(overflow)
   );
   hdl_test #(.CNT_W(4), .DEF_PERIOD(3)) dut_s (
      .clk(clk), .rst(s_rst), .tick_en(s_te), .period_load(1'b0),
      .period_in(16'd0), .evt_ready(1'b0), .evt_valid(s_valid),
      .evt_time(s_time), .evt_seq(s_seq), .tick_count(s_tc),
      .pending(s_pend), .overflow(s_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] t;
      logic [15:0] s;
   } ev_t;
   ev_t q[$];
   int passes = 0, total = 0;
   logic [31:0] m_tc, prev;
   logic [15:0] m_ph, m_per, m_seq;
   bit m_ovf;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock of stimulus: check the head against the scoreboard, advance the model, then check state.
   task automatic step(bit te, bit pl, logic [15:0] pin, bit rdy);
      logic [15:0] last;
      bit pop, ev, acc;
      tick_en = te; period_load = pl; period_in = pin; evt_ready = rdy;
      pop = q.size() > 0 && rdy;
      chk("evt_valid", 64'(evt_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("evt_time", 64'(evt_time), 64'(q[0].t));
         chk("evt_seq", 64'(evt_seq), 64'(q[0].s));
      end
      last = m_per == 0 ? 16'd0 : m_per - 16'd1;
      ev   = te && !pl && m_ph == last;
      acc  = ev && (q.size() < 4 || pop);
      if (pop) void'(q.pop_front());
      if (acc) begin
         q.push_back('{m_tc, m_seq});
         m_seq++;
      end
      if (ev && !acc) m_ovf = 1;
      if (te) m_tc++;
      if (pl) begin
         m_per = pin;
         m_ph  = 0;
      end else if (te) m_ph = ev ? 16'd0 : m_ph + 16'd1;
      @(posedge clk); #1;
      chk("tick_count", 64'(tick_count), 64'(m_tc));
      chk("pending", 64'(pending), 64'(q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   task automatic do_reset();
      rst = 1; tick_en = 1; period_load = 1; period_in = 7; evt_ready = 1;
      @(posedge clk); #1;
      rst = 0;
      q.delete();
      m_tc = 0; m_ph = 0; m_per = 100; m_seq = 0; m_ovf = 0;
      chk("rst_valid", 64'(evt_valid), 64'd0);
      chk("rst_time", 64'(evt_time), 64'd0);
      chk("rst_seq", 64'(evt_seq), 64'd0);
      chk("rst_tick", 64'(tick_count), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
   endtask

   initial begin
      @(posedge clk); #1;
      s_rst = 0; s_te = 1;
      repeat (15) @(posedge clk);
      #1;
      chk("s_tick_15", 64'(s_tc), 64'd15);
      chk("s_pending", 64'(s_pend), 64'd4);
      chk("s_overflow", 64'(s_ovf), 64'd1);
      chk("s_head_time", 64'(s_time), 64'd2);
      @(posedge clk); #1;
      chk("s_tick_wrap", 64'(s_tc), 64'd0);
      s_rst = 1;
      @(posedge clk); #1;
      s_rst = 0; s_te = 0;
      chk("s_rst_tick", 64'(s_tc), 64'd0);
      chk("s_rst_valid", 64'(s_valid), 64'd0);
      chk("s_rst_pending", 64'(s_pend), 64'd0);
      chk("s_rst_overflow", 64'(s_ovf), 64'd0);
      chk("s_rst_time", 64'(s_time), 64'd0);

      do_reset();
      repeat (100) step(1, 0, 0, 1);
      chk("def_tick", 64'(tick_count), 64'd100);
      chk("def_time", 64'(evt_time), 64'd99);
      chk("def_seq", 64'(evt_seq), 64'd0);
      step(0, 0, 0, 1);
      chk("def_one_event", 64'(pending), 64'd0);

      do_reset();
      step(0, 1, 3, 0);
      repeat (12) step(1, 0, 0, 0);
      chk("p3_pending", 64'(pending), 64'd4);
      chk("p3_overflow", 64'(overflow), 64'd0);
      repeat (3) step(1, 0, 0, 0);
      chk("drop_overflow", 64'(overflow), 64'd1);
      chk("drop_pending", 64'(pending), 64'd4);
      repeat (4) step(0, 0, 0, 1);
      repeat (3) step(1, 0, 0, 1);
      chk("after_drop_seq", 64'(evt_seq), 64'd4);
      chk("after_drop_time", 64'(evt_time), 64'd17);

      do_reset();
      step(0, 1, 3, 0);
      repeat (14) step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      chk("full_pushpop_pending", 64'(pending), 64'd4);
      chk("full_pushpop_overflow", 64'(overflow), 64'd0);

      repeat (4) step(0, 0, 0, 1);
      step(0, 1, 0, 1);
      step(1, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         prev = evt_time;
         step(1, 0, 0, 1);
         chk("p0_consecutive", 64'(evt_time), 64'(prev + 32'd1));
      end
      chk("p0_pending", 64'(pending), 64'd1);

      do_reset();
      repeat (5) step(1, 0, 0, 1);
      step(0, 0, 0, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/hdl_test.md
HDL_TEST -- requirements
Module: hdl_test

Interface
REQ-001 Parameter CNT_W, default 32: width of the tick counter and event timestamps.
REQ-002 Parameter PER_W, default 16: width of the period register and event sequence number.
REQ-003 Parameter DEF_PERIOD, default 100: period value loaded by reset.
REQ-004 Parameter DEPTH, default 4: event FIFO depth, power of two.
REQ-005 clk  in  1: single clock; all logic rising-edge.
REQ-006 rst  in  1: synchronous, active-high reset.
REQ-007 tick_en  in  1: advance the time base this cycle.
REQ-008 period_load  in  1: load period_in this cycle.
REQ-009 period_in  in  PER_W: new event period in ticks.
REQ-010 evt_ready  in  1: consumer accepts the head event.
REQ-011 evt_valid  out  1: FIFO non-empty.
REQ-012 evt_time  out  CNT_W: tick_count captured for the head event.
REQ-013 evt_seq  out  PER_W: sequence number of the head event.
REQ-014 tick_count  out  CNT_W: free-running tick counter.
REQ-015 pending  out  clog2(DEPTH)+1: FIFO occupancy.
REQ-016 overflow  out  1: sticky flag, set when an event is dropped.

Function
REQ-017 tick_count SHALL increment by 1 on each clk edge with tick_en=1, and wrap from all-ones to 0.
REQ-018 A phase counter SHALL advance on each tick_en cycle; the cycle it equals period-1 is an event cycle, and the phase counter returns to 0 on that cycle.
REQ-019 Stored period 0 SHALL behave as period 1, so every tick_en cycle is an event cycle.
REQ-020 period_load=1 SHALL store period_in and clear the phase counter; it takes priority over the phase advance in the same cycle, and no event is generated in that cycle.
REQ-021 On an event cycle the FIFO SHALL push {tick_count pre-increment value, seq}; seq then increments modulo 2^PER_W.
REQ-022 evt_valid SHALL be high while pending>0; a pop occurs when evt_valid and evt_ready are both 1.
REQ-023 The head outputs SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-024 The first event SHALL become visible on evt_valid one cycle after the event cycle (one-cycle push latency).
REQ-025 A push and a pop in the same cycle SHALL leave pending unchanged, including when the FIFO is full (no drop).
REQ-026 A push into a full FIFO without a simultaneous pop SHALL drop the event, leave seq unchanged and set overflow; overflow is cleared only by rst.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 A pop with pending=0 SHALL be ignored.

Reset
REQ-029 rst=1 SHALL set tick_count=0, phase=0, seq=0, period=DEF_PERIOD, pending=0, evt_valid=0, overflow=0, and evt_time=0, evt_seq=0.
REQ-030 rst SHALL dominate all other inputs in the same cycle and SHALL discard any in-flight events.

Structure
REQ-031 A shared package hdl_test_pkg SHALL hold the default parameter constants and the event record typedef {time, seq}.
REQ-032 The FIFO SHALL be a sub-module named hdl_test_evt_fifo; the time base, phase counter and sequencer SHALL live in hdl_test.

Verification
REQ-033 Reset, then tick_en=1 for 100 cycles with default period and evt_ready=1 -> exactly one event with evt_time=99 and evt_seq=0; tick_count=100.
REQ-034 Load period 3, tick_en=1 for 12 cycles, evt_ready=0 -> pending=4, seq 0..3 queued, overflow=0.
REQ-035 Continue 3 more ticks from REQ-034 with evt_ready=0 -> 5th event dropped, overflow=1, pending=4; after draining, the next accepted event has evt_seq=4.
REQ-036 Full FIFO with evt_ready=1 on an event cycle -> pending stays 4 and overflow stays 0.
REQ-037 Load period 0 -> an event every tick_en cycle, with evt_time values consecutive.
REQ-038 Preload tick_count to all-ones via ticks (reduced CNT_W=4) -> wraps to 0; rst asserted mid-burst -> all outputs return to their reset values next cycle.
